hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core: decides per cycle which stage registers hold (stall) or load a bubble (flush).
//  Covers load-use hazards on the ID stage (operands/immediate path), EX-stage control-flow redirects and data-memory wait.
//  Sits beside the ID stage; drives enables of PC, IF/ID, ID/EX, EX/MEM, MEM/WB. Also keeps stall/flush perf counters.
// PARAMETERS
//  LOAD_USE_STALL   1    bubbles inserted per load-use hazard (legal 1..3)
//  REDIRECT_BUBBLES 1    cycles IF/ID is squashed after a redirect (legal 1..4, covers imem latency)
//  MEM_TIMEOUT      255  consecutive mem-wait cycles before mem_timeout is raised (legal 1..65535)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  id_rs1,id_rs2  in   5   source register indices of instruction in ID
//  id_use_rs1/2   in   1   ID instruction actually reads rs1 / rs2
//  ex_rd          in   5   destination of instruction in EX
//  ex_memread     in   1   instruction in EX is a load
//  ex_redirect    in   1   EX resolved taken branch/jump (PC target valid this cycle)
//  mem_req        in   1   MEM stage has an active data-memory access
//  mem_ready      in   1   data memory completes access this cycle
//  pc_stall       out  1   hold PC
//  ifid_stall     out  1   hold IF/ID;  ifid_flush out 1 load bubble into IF/ID
//  idex_stall     out  1   hold ID/EX;  idex_flush out 1 load bubble into ID/EX
//  exmem_stall    out  1   hold EX/MEM; memwb_flush out 1 load bubble into MEM/WB
//  mem_timeout    out  1   sticky error: mem wait exceeded MEM_TIMEOUT
//  stall_cycles   out  32  count of cycles with pc_stall=1
//  redirect_count out  32  count of accepted redirects
// BEHAVIOUR
//  States: RUN, LU_HOLD, MEM_WAIT, REDIR_HOLD. Registered state + 2-bit hold counter + 16-bit wait counter.
//  Control outputs are combinational from state and current inputs (same-cycle effect); counters/flags registered.
//  Reset (rst_n=0, async): state=RUN, counters 0, mem_timeout=0; all stall/flush outputs 0.
//  lu = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  mem_busy = mem_req & ~mem_ready.
//  Priority per cycle: mem_busy > ex_redirect > REDIR_HOLD > LU_HOLD > lu > normal.
//  mem_busy (any state): pc/ifid/idex/exmem_stall=1, memwb_flush=1, no other flush; go MEM_WAIT, current state and
//    hold counter saved and restored when mem_busy drops. Wait counter +1 per busy cycle, cleared on exit;
//    reaching MEM_TIMEOUT sets mem_timeout (stays set until reset); freeze continues regardless.
//  ex_redirect (not mem_busy): ifid_flush=1, idex_flush=1, no stalls; redirect_count+1.
//    If REDIRECT_BUBBLES>1: enter REDIR_HOLD for REDIRECT_BUBBLES-1 cycles, ifid_flush=1 only.
//    New redirect inside REDIR_HOLD restarts count. Any pending LU_HOLD is cancelled (consumer squashed).
//  lu in RUN: pc_stall=1, ifid_stall=1, idex_flush=1; if LOAD_USE_STALL>1 enter LU_HOLD for LOAD_USE_STALL-1
//    further cycles with same outputs, independent of lu; then RUN.
//  lu during REDIR_HOLD ignored (ID being flushed).
//  ex_rd=0 never creates a hazard. Counters wrap 2^32-1 -> 0.
//  Reset asserted mid-hold/mid-wait: immediate return to RUN, nothing resumed.
// TESTING
//  lw x5 in EX, ID reads rs1=x5 -> 1 cycle pc_stall/ifid_stall/idex_flush, stall_cycles=1; rs1=x0 load to x0 -> no stall.
//  LOAD_USE_STALL=3, lu once -> exactly 3 consecutive stall+bubble cycles, then RUN.
//  ex_redirect 1 cycle, REDIRECT_BUBBLES=2 -> cycle0 ifid_flush+idex_flush, cycle1 ifid_flush only; redirect_count=1.
//  mem_req=1, mem_ready low 4 cycles -> 4 cycles full freeze+memwb_flush, stall_cycles=4; ex_redirect held meanwhile acts on cycle 5.
//  MEM_TIMEOUT=3, mem_ready low 5 cycles -> mem_timeout=1 from 3rd wait cycle on, stays 1 after mem_ready.
//  Reset pulse during LU_HOLD (LOAD_USE_STALL=3, cycle 2) -> outputs 0 immediately, counters 0, RUN after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-side hazard inputs and stage control outputs |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_stall;
  logic        idex_flush;
  logic        exmem_stall;
  logic        memwb_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, mem_timeout, stall_cycles, redirect_count
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, mem_timeout, stall_cycles, redirect_count
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +-----------------------------------------------------------------------+
// | hazard_ctrl : 5-stage pipeline stall/flush sequencer with perf counters |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl #(
  parameter int LOAD_USE_STALL   = 1,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  wire          clk,
  input  wire          rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_HOLD    = 2'd1,
    MEM_WAIT   = 2'd2,
    REDIR_HOLD = 2'd3
  } state_t;

  // Hold counter holds the number of hold cycles still to follow the current one.
  localparam logic [1:0]  c_LU_RELOAD  = (LOAD_USE_STALL > 1)   ? 2'(LOAD_USE_STALL - 2)   : 2'd0;
  localparam logic [1:0]  c_RB_RELOAD  = (REDIRECT_BUBBLES > 1) ? 2'(REDIRECT_BUBBLES - 2) : 2'd0;
  localparam logic [16:0] c_TIMEOUT    = 17'(MEM_TIMEOUT);

  state_t      r_state, r_saved_state;
  logic [1:0]  r_hold, r_saved_hold;
  logic [15:0] r_wait;
  logic        r_timeout;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirect_count;

  state_t      w_cur_state, w_next_state, w_next_saved_state;
  logic [1:0]  w_cur_hold, w_next_hold, w_next_saved_hold;
  logic        w_lu, w_mem_busy, w_redirect_acc;
  logic        w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
  logic        w_idex_flush, w_exmem_stall, w_memwb_flush;
  logic [16:0] w_wait_inc;

  assign w_lu = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  assign w_mem_busy = hz.mem_req && !hz.mem_ready;
  assign w_wait_inc = {1'b0, r_wait} + 17'd1;

  always_comb begin
    w_pc_stall         = 1'b0;
    w_ifid_stall       = 1'b0;
    w_ifid_flush       = 1'b0;
    w_idex_stall       = 1'b0;
    w_idex_flush       = 1'b0;
    w_exmem_stall      = 1'b0;
    w_memwb_flush      = 1'b0;
    w_redirect_acc     = 1'b0;
    w_next_state       = RUN;
    w_next_hold        = 2'd0;
    w_next_saved_state = r_saved_state;
    w_next_saved_hold  = r_saved_hold;
    // While frozen, the interrupted state is evaluated as soon as the wait ends.
    w_cur_state = (r_state == MEM_WAIT) ? r_saved_state : r_state;
    w_cur_hold  = (r_state == MEM_WAIT) ? r_saved_hold  : r_hold;

    if (w_mem_busy) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idex_stall  = 1'b1;
      w_exmem_stall = 1'b1;
      w_memwb_flush = 1'b1;
      w_next_state  = MEM_WAIT;
      w_next_hold   = r_hold;
      if (r_state != MEM_WAIT) begin
        w_next_saved_state = r_state;
        w_next_saved_hold  = r_hold;
      end
    end else if (hz.ex_redirect) begin
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_redirect_acc = 1'b1;
      if (REDIRECT_BUBBLES > 1) begin
        w_next_state = REDIR_HOLD;
        w_next_hold  = c_RB_RELOAD;
      end
    end else begin
      case (w_cur_state)
        REDIR_HOLD: begin
          w_ifid_flush = 1'b1;
          if (w_cur_hold != 2'd0) begin
            w_next_state = REDIR_HOLD;
            w_next_hold  = w_cur_hold - 2'd1;
          end
        end
        LU_HOLD: begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_flush = 1'b1;
          if (w_cur_hold != 2'd0) begin
            w_next_state = LU_HOLD;
            w_next_hold  = w_cur_hold - 2'd1;
          end
        end
        default: begin
          if (w_lu) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              w_next_state = LU_HOLD;
              w_next_hold  = c_LU_RELOAD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_hold        <= 2'd0;
      r_saved_state <= RUN;
      r_saved_hold  <= 2'd0;
    end else begin
      r_state       <= w_next_state;
      r_hold        <= w_next_hold;
      r_saved_state <= w_next_saved_state;
      r_saved_hold  <= w_next_saved_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait           <= 16'd0;
      r_timeout        <= 1'b0;
      r_stall_cycles   <= 32'd0;
      r_redirect_count <= 32'd0;
    end else begin
      if (w_mem_busy) begin
        if (r_wait != 16'hFFFF) r_wait <= w_wait_inc[15:0];
        if (w_wait_inc >= c_TIMEOUT) r_timeout <= 1'b1;
      end else begin
        r_wait <= 16'd0;
      end
      if (w_pc_stall)     r_stall_cycles   <= r_stall_cycles + 32'd1;
      if (w_redirect_acc) r_redirect_count <= r_redirect_count + 32'd1;
    end
  end

  // Controls are combinational, so they are forced low while reset is held.
  assign hz.pc_stall       = w_pc_stall    & rst_n;
  assign hz.ifid_stall     = w_ifid_stall  & rst_n;
  assign hz.ifid_flush     = w_ifid_flush  & rst_n;
  assign hz.idex_stall     = w_idex_stall  & rst_n;
  assign hz.idex_flush     = w_idex_flush  & rst_n;
  assign hz.exmem_stall    = w_exmem_stall & rst_n;
  assign hz.memwb_flush    = w_memwb_flush & rst_n;
  assign hz.mem_timeout    = r_timeout;
  assign hz.stall_cycles   = r_stall_cycles;
  assign hz.redirect_count = r_redirect_count;

endmodule

`default_nettype wire
